// File: rtl/vproc_div_issue.sv
`default_nettype none
// ============================================================================
// Module   : vproc_div_issue
// Purpose  : Issue/retire wrapper around the fixed-latency, non-stallable
//            vproc_div_block divider. It accepts 32-bit divide/remainder
//            requests, extends the operands to 33 bits and tracks in-flight
//            operations with a valid/tag delay line. Results are captured into
//            a result FIFO, and credit-based issue keeps any result from being
//            dropped.
// Ports    : clk_i, sync_rst_i          - clock, synchronous active-high reset
//            op_valid_i/op_ready_o      - request handshake
//            op_a_i, op_b_i             - dividend, divisor
//            op_signed_i, op_mod_i      - signedness, remainder select
//            op_tag_i                   - opaque tag returned with the result
//            div_op1_o/div_op2_o        - extended operands to the divider
//            div_mod_o                  - mod select to the divider
//            div_res_i                  - divider result
//            res_valid_o/res_ready_i    - result handshake
//            res_o, res_tag_o           - result FIFO head
// Revision : 1.0 - initial release
// ============================================================================
module vproc_div_issue #(
  parameter int unsigned DIV_LAT   = 3,
  parameter int unsigned MOD_DLY   = 1,
  parameter int unsigned RES_DEPTH = 5,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk_i,
  input  logic             sync_rst_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic             op_signed_i,
  input  logic             op_mod_i,
  input  logic [TAG_W-1:0] op_tag_i,
  output logic [32:0]      div_op1_o,
  output logic [32:0]      div_op2_o,
  output logic             div_mod_o,
  input  logic [31:0]      div_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic [TAG_W-1:0] res_tag_o
);

  localparam int unsigned C_PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned C_CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(RES_DEPTH);
  localparam logic [C_PTR_W-1:0] C_LAST  = C_PTR_W'(RES_DEPTH - 1);

  logic               acc, pop, push;
  logic [32:0]        op1_q, op1_d, op2_q, op2_d;
  logic [MOD_DLY:0]   mod_q, mod_d;
  logic [DIV_LAT:0]   trk_vld_q, trk_vld_d;
  logic [TAG_W-1:0]   trk_tag_q [DIV_LAT+1];
  logic [TAG_W-1:0]   trk_tag_d [DIV_LAT+1];
  logic [C_CNT_W-1:0] cnt_q, cnt_d;     // in-flight + queued
  logic [C_CNT_W-1:0] fcnt_q, fcnt_d;   // FIFO occupancy
  logic [C_PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]        mem_res_q [RES_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [RES_DEPTH];

  assign res_valid_o = (fcnt_q != '0);
  assign pop         = res_valid_o & res_ready_i;
  // A pop this cycle frees a credit, so a full credit pool can still accept.
  assign op_ready_o  = !sync_rst_i & ((cnt_q < C_DEPTH) | pop);
  assign acc         = op_valid_i & op_ready_o;
  // The last tracking stage lines up with the divider's result.
  assign push        = trk_vld_q[DIV_LAT];

  assign div_op1_o   = op1_q;
  assign div_op2_o   = op2_q;
  assign div_mod_o   = mod_q[MOD_DLY];
  // Head is masked while empty; the data RAM itself is never cleared.
  assign res_o       = res_valid_o ? mem_res_q[rd_q] : '0;
  assign res_tag_o   = res_valid_o ? mem_tag_q[rd_q] : '0;

  always_comb begin
    // Idle cycles drive zero operands into the divider.
    op1_d = '0;
    op2_d = '0;
    if (acc) begin
      op1_d = {op_signed_i & op_a_i[31], op_a_i};
      op2_d = {op_signed_i & op_b_i[31], op_b_i};
    end

    mod_d    = '0;
    mod_d[0] = acc & op_mod_i;
    for (int i = 1; i <= int'(MOD_DLY); i++) begin
      mod_d[i] = mod_q[i-1];
    end

    trk_vld_d    = '0;
    trk_vld_d[0] = acc;
    trk_tag_d[0] = acc ? op_tag_i : '0;
    for (int i = 1; i <= int'(DIV_LAT); i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
    end

    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase

    wr_d = wr_q;
    if (push) wr_d = (wr_q == C_LAST) ? '0 : wr_q + 1'b1;
    rd_d = rd_q;
    if (pop) rd_d = (rd_q == C_LAST) ? '0 : rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      op1_q     <= '0;
      op2_q     <= '0;
      mod_q     <= '0;
      trk_vld_q <= '0;
      for (int i = 0; i <= int'(DIV_LAT); i++) trk_tag_q[i] <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      mod_q     <= mod_d;
      trk_vld_q <= trk_vld_d;
      for (int i = 0; i <= int'(DIV_LAT); i++) trk_tag_q[i] <= trk_tag_d[i];
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !sync_rst_i) begin
      mem_res_q[wr_q] <= div_res_i;
      mem_tag_q[wr_q] <= trk_tag_q[DIV_LAT];
    end
  end

  // Credits bound in-flight + queued work, so a write into a full FIFO
  // without a simultaneous pop must never happen.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (sync_rst_i)
    !(push && (fcnt_q == C_DEPTH) && !pop));

endmodule
`default_nettype wire

// File: doc/vproc_div_issue.md
# vproc_div_issue

Issue and retire stage wrapped around `vproc_div_block`, which is a fixed-latency pipeline with no handshake. The block accepts 32-bit divide/remainder requests over a valid/ready handshake and sign- or zero-extends the operands to 33 bits. It drives the divider's `op1_i`/`op2_i`/`mod` ports with the correct alignment, tracks in-flight operations with a valid/tag delay line, and captures `res_o` into a result FIFO. Credit-based issue guarantees that a result is never dropped, even though the divider pipeline cannot stall.

## Interface
- `DIV_LAT`, 3: cycles from `div_op1_o`/`div_op2_o` presented to `div_res_i` valid; 3 matches `BUF_OPS`=`BUF_DIV`=`BUF_RES`=1; legal range 0..7.
- `MOD_DLY`, 1: cycles `div_mod_o` lags the operands; equals the divider's `BUF_OPS`; 0 or 1.
- `RES_DEPTH`, 5: result FIFO entries; at least 1; full throughput needs `DIV_LAT`+2 or more.
- `TAG_W`, 4: width of the opaque request tag.
- `clk_i` in 1: clock, rising edge.
- `sync_rst_i` in 1: synchronous reset, active-high.
- `op_valid_i` in 1: request valid.
- `op_ready_o` out 1: request accepted when high together with `op_valid_i`.
- `op_a_i` in 32: dividend.
- `op_b_i` in 32: divisor.
- `op_signed_i` in 1: 1 = DIV/REM, 0 = DIVU/REMU.
- `op_mod_i` in 1: 0 = quotient, 1 = remainder.
- `op_tag_i` in `TAG_W`: tag returned with the result.
- `div_op1_o` out 33: extended dividend to the divider.
- `div_op2_o` out 33: extended divisor to the divider.
- `div_mod_o` out 1: mod select to the divider.
- `div_res_i` in 32: divider result.
- `res_valid_o` out 1: FIFO head valid.
- `res_ready_i` in 1: consumer pops the head when high together with `res_valid_o`.
- `res_o` out 32: head result.
- `res_tag_o` out `TAG_W`: head tag.

## Operation
- Accept: `acc = op_valid_i & op_ready_o`.
- Extension: signed requests use `{x[31],x}`; unsigned requests use `{1'b0,x}`. Applies to both operands.
- The divider's zero-divisor and overflow rules yield RISC-V results unchanged:
  - div-by-0 gives quotient 0xFFFFFFFF and remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- Operand regs: on `acc`, `div_op1_o`/`div_op2_o` load the extended values. Otherwise they load 0. Either way the new value appears the next cycle.
- Mod delay line: `div_mod_o` is the mod bit registered on `acc`, delayed by a further `MOD_DLY` cycles. This aligns it with the divider's buffered operands.
- Tracking: a valid/tag/mod shift register of length 1+`DIV_LAT` runs in parallel with the divider. Its output stage marks the cycle in which `div_res_i` belongs to an accepted request.
- Result capture: when the tracking output is valid, `{div_res_i, tag}` is written to the FIFO tail. Invalid slots are never written.
- Credits:
  - `cnt` = in-flight + FIFO occupancy.
  - `op_ready_o = !sync_rst_i & (cnt < RES_DEPTH | pop)`, where `pop = res_valid_o & res_ready_i`.
  - `cnt` updates as `cnt + acc - pop`; a simultaneous accept and pop leaves `cnt` unchanged.
  - Invariant: FIFO overflow is impossible. Assert FIFO write-when-full never occurs.
- FIFO: circular buffer with read/write pointers that wrap at `RES_DEPTH`. Push and pop in the same cycle on a full FIFO is legal. Push and pop in the same cycle on an empty FIFO does not bypass: a value written this cycle becomes visible next cycle.
- Reset: while `sync_rst_i` is high, all state clears at the edge:
  - shift register, FIFO pointers, `cnt`;
  - `div_op1_o`/`div_op2_o`/`div_mod_o` = 0;
  - `res_valid_o` = 0; `res_o`/`res_tag_o` = 0 (data RAM is not cleared, but the outputs are masked while empty).
- Reset mid-operation discards all in-flight and queued results. Divider outputs produced after reset are ignored because the tracking valids are clear.

## Timing
- Accept in cycle t:
  - operands on `div_op*_o` in t+1;
  - `div_mod_o` in t+1+`MOD_DLY`;
  - `div_res_i` sampled in t+1+`DIV_LAT`;
  - `res_valid_o` earliest at t+2+`DIV_LAT` (5 with defaults).
- Throughput: one request per cycle when `RES_DEPTH` ≥ `DIV_LAT`+2 and the consumer is always ready.
- Results leave in acceptance order; no reordering.
- `op_ready_o` depends combinationally on `res_ready_i` through `pop`. The request side must not combinationally depend on `op_ready_o` back toward `res_ready_i`.
- All outputs except `op_ready_o` are registered.

## Test plan
- Unsigned: 100/7 DIVU then REMU, tags 1 and 2 → results 14 (tag 1) then 2 (tag 2); first `res_valid_o` 5 cycles after accept.
- Signed edge cases, issued back-to-back:
  - −7/2 → 0xFFFFFFFD;
  - REM −7/2 → 0xFFFFFFFF;
  - 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same → 0;
  - DIV 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5.
- Unsigned large: DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF, which confirms zero extension.
- Backpressure: hold `res_ready_i`=0 and drive `op_valid_i`=1 → exactly 5 accepts, then `op_ready_o`=0. Release → 5 results in order, and `op_ready_o` rises in the same cycle as the first pop.
- Streaming: 64 random requests with `res_ready_i`=1 → one accept per cycle, all results match the reference model, and the FIFO never overflows.
- Reset mid-flight: accept 3 requests, assert `sync_rst_i` for 1 cycle at t+2 → no `res_valid_o` afterwards, and the first post-reset request returns its correct value.
